databus_responder: RTL and testbench

Memory-side endpoint of the Versat databus. It accepts burst requests from NUM_MASTERS databus masters (VRead and VWrite units) and arbitrates them round-robin. Each granted burst runs against a single-port synchronous SRAM with 1-cycle read latency. Per beat, the responder returns `databus_ready`, `databus_last` and the shared `databus_rdata` that the masters consume.

---
 rtl/databus_responder.sv | 203 ++++++++++++++++++++
 tb/tb_databus_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/databus_responder.sv
// Memory-side databus endpoint: round-robin arbitration of burst requests from
// several masters onto one single-port synchronous SRAM with 1-cycle read latency.
module databus_responder #(
    parameter int NUM_MASTERS = 3,
    parameter int AXI_ADDR_W  = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_ADDR_W  = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            databus_valid,
    input  logic [NUM_MASTERS*AXI_ADDR_W-1:0] databus_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]     databus_wdata,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0] databus_wstrb,
    input  logic [NUM_MASTERS*8-1:0]          databus_len,
    output logic [NUM_MASTERS-1:0]            databus_ready,
    output logic [NUM_MASTERS-1:0]            databus_last,
    output logic [DATA_W-1:0]                 databus_rdata,
    output logic                              mem_en,
    output logic [DATA_W/8-1:0]               mem_we,
    output logic [MEM_ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic [DATA_W-1:0]                 mem_rdata,
    output logic                              busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_TAIL = 2'd3
    } state_t;

    state_t                  state_r, state_nx_s;
    logic [IDX_W-1:0]        rr_ptr_r, rr_ptr_nx_s;
    logic [NUM_MASTERS-1:0]  mask_r, mask_nx_s;
    logic [8:0]              beat_r, beat_nx_s;
    logic [MEM_ADDR_W-1:0]   base_r, base_nx_s;
    logic [7:0]              len_q_r, len_q_nx_s;
    logic [IDX_W-1:0]        grant_r, grant_nx_s;
    logic [DATA_W-1:0]       rdata_r, rdata_nx_s;

    logic [MEM_ADDR_W-1:0]   word_s  [NUM_MASTERS];
    logic [7:0]              len_s   [NUM_MASTERS];
    logic [STRB_W-1:0]       wstrb_s [NUM_MASTERS];
    logic [DATA_W-1:0]       wdata_s [NUM_MASTERS];

    logic [NUM_MASTERS-1:0]  req_s;
    logic [IDX_W:0]          arb_sum_s;
    logic                    arb_hit_s;
    logic                    found_s;
    logic [IDX_W-1:0]        win_s;
    logic [IDX_W-1:0]        next_rr_s;
    logic                    at_len_s;
    logic                    rd_beat_s;
    logic [MEM_ADDR_W-1:0]   cur_addr_s;

    // Byte addresses reduce to word addresses; bits [1:0] and the upper bits drop out.
    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign word_s[g]  = databus_addr[g*AXI_ADDR_W + 2 +: MEM_ADDR_W];
        assign len_s[g]   = databus_len[g*8 +: 8];
        assign wstrb_s[g] = databus_wstrb[g*STRB_W +: STRB_W];
        assign wdata_s[g] = databus_wdata[g*DATA_W +: DATA_W];
    end

    assign next_rr_s  = (grant_r == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_r + 1'b1;
    assign at_len_s   = (beat_r == {1'b0, len_q_r});
    assign cur_addr_s = base_r + MEM_ADDR_W'(beat_r);
    assign busy       = (state_r != IDLE);

    // Round-robin pick: first unmasked requester at or after rr_ptr.
    always_comb begin
        req_s     = databus_valid & ~mask_r;
        found_s   = 1'b0;
        win_s     = '0;
        arb_sum_s = '0;
        arb_hit_s = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            arb_sum_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
            arb_sum_s = (arb_sum_s >= (IDX_W+1)'(NUM_MASTERS)) ?
                        arb_sum_s - (IDX_W+1)'(NUM_MASTERS) : arb_sum_s;
            arb_hit_s = !found_s && req_s[arb_sum_s[IDX_W-1:0]];
            win_s     = arb_hit_s ? arb_sum_s[IDX_W-1:0] : win_s;
            found_s   = found_s | arb_hit_s;
        end
    end

    // Burst FSM: next-state, datapath updates and per-beat bus/SRAM decode.
    always_comb begin
        state_nx_s    = state_r;
        rr_ptr_nx_s   = rr_ptr_r;
        mask_nx_s     = mask_r;
        beat_nx_s     = beat_r;
        base_nx_s     = base_r;
        len_q_nx_s    = len_q_r;
        grant_nx_s    = grant_r;
        rd_beat_s     = 1'b0;
        mem_en        = 1'b0;
        mem_we        = '0;
        mem_addr      = '0;
        mem_wdata     = '0;
        databus_ready = '0;
        databus_last  = '0;
        case (state_r)
            IDLE: begin
                mask_nx_s = '0;
                if (found_s) begin
                    grant_nx_s = win_s;
                    base_nx_s  = word_s[win_s];
                    len_q_nx_s = len_s[win_s];
                    beat_nx_s  = 9'd0;
                    state_nx_s = (wstrb_s[win_s] != '0) ? WR : RD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WR: begin
                if (databus_valid[grant_r]) begin
                    mem_en                 = 1'b1;
                    mem_we                 = wstrb_s[grant_r];
                    mem_addr               = cur_addr_s;
                    mem_wdata              = wdata_s[grant_r];
                    databus_ready[grant_r] = 1'b1;
                    beat_nx_s              = beat_r + 9'd1;
                    if (at_len_s) begin
                        databus_last[grant_r] = 1'b1;
                        state_nx_s            = IDLE;
                        rr_ptr_nx_s           = next_rr_s;
                        mask_nx_s             = '0;
                        mask_nx_s[grant_r]    = 1'b1;
                    end else begin
                        state_nx_s = WR;
                    end
                end else begin
                    state_nx_s = WR;
                end
            end
            RD: begin
                mem_en    = 1'b1;
                mem_addr  = cur_addr_s;
                beat_nx_s = beat_r + 9'd1;
                // The first RD cycle only issues; data for beat-1 comes back afterwards.
                if (beat_r != 9'd0) begin
                    databus_ready[grant_r] = 1'b1;
                    rd_beat_s              = 1'b1;
                end else begin
                    rd_beat_s = 1'b0;
                end
                if (at_len_s) begin
                    state_nx_s = RD_TAIL;
                end else begin
                    state_nx_s = RD;
                end
            end
            RD_TAIL: begin
                databus_ready[grant_r] = 1'b1;
                databus_last[grant_r]  = 1'b1;
                rd_beat_s              = 1'b1;
                state_nx_s             = IDLE;
                rr_ptr_nx_s            = next_rr_s;
                mask_nx_s              = '0;
                mask_nx_s[grant_r]     = 1'b1;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
        if (rd_beat_s) begin
            rdata_nx_s    = mem_rdata;
            databus_rdata = mem_rdata;
        end else begin
            rdata_nx_s    = rdata_r;
            databus_rdata = rdata_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            rr_ptr_r <= '0;
            mask_r   <= '0;
            beat_r   <= 9'd0;
            base_r   <= '0;
            len_q_r  <= 8'd0;
            grant_r  <= '0;
            rdata_r  <= '0;
        end else begin
            state_r  <= state_nx_s;
            rr_ptr_r <= rr_ptr_nx_s;
            mask_r   <= mask_nx_s;
            beat_r   <= beat_nx_s;
            base_r   <= base_nx_s;
            len_q_r  <= len_q_nx_s;
            grant_r  <= grant_nx_s;
            rdata_r  <= rdata_nx_s;
        end
    end

endmodule

// File: tb/tb_databus_responder.sv
// Randomized bench for databus_responder: master agents, an SRAM device and a
// burst-level reference model that predicts every bus and SRAM output per cycle.
module tb_databus_responder;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 10;
    localparam int SW = DW / 8;
    localparam int DEPTH = 1 << MW;
    localparam int CYCLES = 6000;

    logic clk_s = 1'b0;
    logic rst_s;
    logic [N-1:0]          valid_s;
    logic [N-1:0][AW-1:0]  addr_s;
    logic [N-1:0][DW-1:0]  wdata_s;
    logic [N-1:0][SW-1:0]  wstrb_s;
    logic [N-1:0][7:0]     len_s;
    logic [N-1:0]          ready_s;
    logic [N-1:0]          last_s;
    logic [DW-1:0]         rdata_s;
    logic                  mem_en_s;
    logic [SW-1:0]         mem_we_s;
    logic [MW-1:0]         mem_addr_s;
    logic [DW-1:0]         mem_wdata_s;
    logic [DW-1:0]         mem_rdata_s = '0;
    logic                  busy_s;

    always #5 clk_s = ~clk_s;

    databus_responder #(
        .NUM_MASTERS(N), .AXI_ADDR_W(AW), .DATA_W(DW), .MEM_ADDR_W(MW)
    ) dut (
        .clk(clk_s), .rst(rst_s),
        .databus_valid(valid_s), .databus_addr(addr_s), .databus_wdata(wdata_s),
        .databus_wstrb(wstrb_s), .databus_len(len_s),
        .databus_ready(ready_s), .databus_last(last_s), .databus_rdata(rdata_s),
        .mem_en(mem_en_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
        .mem_wdata(mem_wdata_s), .mem_rdata(mem_rdata_s), .busy(busy_s)
    );

    function automatic logic [DW-1:0] init_word(input int w);
        logic [31:0] wv;
        wv = 32'(w);
        return (wv * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] wd,
                                            input logic [SW-1:0] we);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++) begin
            if (we[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    // SRAM device: byte-enabled writes, registered read data one cycle after a read.
    logic [DW-1:0] sram_r    [DEPTH];
    bit            written_r [DEPTH];
    always @(posedge clk_s) begin
        if (mem_en_s) begin
            if (mem_we_s != '0) begin
                sram_r[mem_addr_s]    <= merge(written_r[mem_addr_s] ? sram_r[mem_addr_s]
                                               : init_word(int'(mem_addr_s)), mem_wdata_s, mem_we_s);
                written_r[mem_addr_s] <= 1'b1;
            end else begin
                mem_rdata_s <= written_r[mem_addr_s] ? sram_r[mem_addr_s]
                               : init_word(int'(mem_addr_s));
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: expected memory plus the burst currently being served.
    logic [DW-1:0] gold [DEPTH];
    int  m_own, m_rr, m_mask, m_word, m_len, m_iss, m_ret;
    bit  m_wr;
    logic [DW-1:0] m_hold;

    // Master agents.
    bit   act [N];
    bit   is_wr [N];
    int   gap [N];
    logic [AW-1:0] a_addr [N];
    logic [7:0]    a_len [N];
    logic [N-1:0]  saw_last;
    int   n_bursts = 0;

    task automatic start_burst(input int i);
        int r, word;
        act[i]   = 1'b1;
        is_wr[i] = ($urandom_range(0, 1) == 1);
        r        = $urandom_range(0, 9);
        a_len[i] = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(1, 7));
        word     = ($urandom_range(0, 3) == 0) ? $urandom_range(1016, 1023) : $urandom_range(0, 1023);
        a_addr[i] = ($urandom() & 32'hFFFF_F000) | 32'(word << 2) | 32'($urandom_range(0, 3));
    endtask

    initial begin
        logic [N-1:0]  e_rdy, e_last;
        logic          e_en, e_busy, fin;
        logic [SW-1:0] e_we;
        logic [MW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_rd;
        int w, j, gi;

        for (int k = 0; k < DEPTH; k++) gold[k] = init_word(k);
        m_own = -1; m_rr = 0; m_mask = -1; m_hold = '0;
        m_word = 0; m_len = 0; m_iss = 0; m_ret = 0; m_wr = 1'b0;
        saw_last = '0;
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; is_wr[i] = 1'b0; gap[i] = 0; a_addr[i] = '0; a_len[i] = '0;
        end
        rst_s = 1'b0; valid_s = '0; addr_s = '0; wdata_s = '0; wstrb_s = '0; len_s = '0;

        for (cyc = 0; cyc < CYCLES; cyc++) begin
            @(posedge clk_s);
            #1;
            rst_s = !(cyc < 3 || cyc == 2500 || (cyc > 100 && $urandom_range(0, 1499) == 0));
            for (int i = 0; i < N; i++) begin
                if (!rst_s) begin
                    act[i] = 1'b0;
                    gap[i] = 0;
                end else if (cyc == 3 && i == 0) begin
                    // Long read that crosses the top of the word space, byte offset 3.
                    act[i] = 1'b1; is_wr[i] = 1'b0; a_len[i] = 8'd255;
                    a_addr[i] = 32'h0000_0FF3;
                end else if (act[i]) begin
                    if (saw_last[i]) begin
                        act[i] = 1'b0;
                        gap[i] = $urandom_range(1, 3);
                        n_bursts++;
                    end
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end else if ($urandom_range(0, 2) != 0) begin
                    start_burst(i);
                end
                valid_s[i] = act[i] && !(is_wr[i] && $urandom_range(0, 7) == 0);
                addr_s[i]  = a_addr[i];
                len_s[i]   = a_len[i];
                wstrb_s[i] = (act[i] && is_wr[i]) ? SW'($urandom_range(1, 15)) : '0;
                wdata_s[i] = $urandom();
            end

            @(negedge clk_s);
            e_rdy = '0; e_last = '0; e_en = 1'b0; e_we = '0; e_addr = '0; e_wd = '0;
            e_busy = 1'b0; fin = 1'b0; e_rd = m_hold;
            if (!rst_s) begin
                m_own = -1; m_rr = 0; m_mask = -1; m_hold = '0; e_rd = '0;
            end else if (m_own < 0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    j = (m_rr + k) % N;
                    if (w < 0 && valid_s[j] && j != m_mask) w = j;
                end
                m_mask = -1;
                if (w >= 0) begin
                    m_own = w; m_wr = (wstrb_s[w] != '0);
                    m_word = int'(addr_s[w][MW+1:2]); m_len = int'(len_s[w]);
                    m_iss = 0; m_ret = 0;
                end
            end else begin
                e_busy = 1'b1;
                if (m_wr) begin
                    if (valid_s[m_own]) begin
                        gi = (m_word + m_ret) % DEPTH;
                        e_en = 1'b1; e_we = wstrb_s[m_own]; e_addr = MW'(gi);
                        e_wd = wdata_s[m_own]; e_rdy[m_own] = 1'b1;
                        fin = (m_ret == m_len); e_last[m_own] = fin;
                        gold[gi] = merge(gold[gi], wdata_s[m_own], wstrb_s[m_own]);
                        m_ret++;
                    end
                end else begin
                    if (m_ret < m_iss) begin
                        e_rd = gold[(m_word + m_ret) % DEPTH]; m_hold = e_rd;
                        e_rdy[m_own] = 1'b1;
                        fin = (m_ret == m_len); e_last[m_own] = fin;
                        m_ret++;
                    end
                    if (m_iss <= m_len) begin
                        e_en = 1'b1; e_addr = MW'((m_word + m_iss) % DEPTH);
                        m_iss++;
                    end
                end
                if (fin) begin
                    m_rr = (m_own + 1) % N; m_mask = m_own; m_own = -1;
                end
            end

            check_eq("ready", ready_s, e_rdy);
            check_eq("last", last_s, e_last);
            check_eq("mem_en", mem_en_s, e_en);
            check_eq("mem_we", mem_we_s, e_we);
            check_eq("busy", busy_s, e_busy);
            check_eq("rdata", rdata_s, e_rd);
            if (e_en) begin
                check_eq("mem_addr", mem_addr_s, e_addr);
            end else if (!e_busy) begin
                check_eq("mem_addr_idle", mem_addr_s, '0);
            end
            if (e_we != '0 || !e_busy) check_eq("mem_wdata", mem_wdata_s, e_wd);
            saw_last = last_s;
        end

        check_eq("bursts_done", 64'(n_bursts > 20), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
